io_1ton_chk: RTL and testbench

// - Parametrised traffic generator/checker for NoC node tests: one source channel, NUM_SNK sink channels.
// - Source sends a numbered stream to destination addresses MIN_ADDR..MAX_ADDR (wrapping), one 4-phase req/ack message at a time.
// - Each sink checks routing (dst owns its slot), data range and per-sink sequence continuity.
// - Sits at top level of vl_tests benches, wrapped around the DUT's in/out channels.

---
 rtl/io_1ton_chk_pkg.sv | 26 ++
 rtl/hglobal.sv | 19 +
 rtl/io_1ton_chk_snk.sv | 86 ++++++++
 rtl/io_1ton_chk.sv | 180 ++++++++++++++++++
 tb/tb_io_1ton_chk.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/io_1ton_chk_pkg.sv
// Types and helpers shared by the 1-to-N traffic generator/checker.
// Latency: n/a (package).
// Backpressure: n/a.
`ifndef NS_HGLOBAL_SV
`include "hglobal.sv"
`endif

package io_1ton_chk_pkg;

  typedef enum logic {
    SRC_IDLE = `NS_IO_SRC_IDLE,
    SRC_WAIT = `NS_IO_SRC_WAIT
  } src_st_t;

  localparam int             RX_W   = 32;
  localparam logic [RX_W-1:0] RX_MAX = '1;

  // Receive counter add that sticks at all-ones instead of wrapping.
  function automatic logic [RX_W-1:0] sat_add(input logic [RX_W-1:0] a,
                                               input logic [RX_W-1:0] b);
    logic [RX_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[RX_W] ? RX_MAX : s[RX_W-1:0];
  endfunction

endpackage

// File: rtl/hglobal.sv
// Shared NoC test constants and helper macros.
// Latency: n/a (definitions only).
// Backpressure: n/a.
`ifndef NS_HGLOBAL_SV
`define NS_HGLOBAL_SV

`define NS_ON            1'b1
`define NS_OFF           1'b0
`define NS_ADDRESS_SIZE  8
`define NS_DATA_SIZE     8

// Source FSM state codes for the 1-to-N traffic checker.
`define NS_IO_SRC_IDLE   1'b0
`define NS_IO_SRC_WAIT   1'b1

// Sink slot owning address a: the low w bits of the address.
`define NS_SLOT(a, w)    a[(w)-1:0]

`endif

// File: rtl/io_1ton_chk_snk.sv
// Purpose: one sink checker - acks a 4-phase message and checks routing, range, sequence.
// Latency: ack rises 1 cycle after req rises, drops 1 cycle after req drops.
// Backpressure: none; every request is accepted on its first cycle.
// Ports: i_clk/i_rst, i_dst/i_dat/i_req (incoming message), o_ack,
//        o_err (sticky), o_acc (acceptance strobe), o_fst_inp/o_fst_exp (first error capture).
`ifndef NS_HGLOBAL_SV
`include "hglobal.sv"
`endif

module io_snk_chk
  import io_1ton_chk_pkg::*;
#(
  parameter int IDX   = 0,
  parameter int SEL_W = 2,
  parameter int ASZ   = 8,
  parameter int DSZ   = 8,
  parameter int CNT_W = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [ASZ-1:0] i_dst,
  input  logic [DSZ-1:0] i_dat,
  input  logic           i_req,
  output logic           o_ack,
  output logic           o_err,
  output logic           o_acc,
  output logic [DSZ-1:0] o_fst_inp,
  output logic [DSZ-1:0] o_fst_exp
);

  logic             r_ack;
  logic [CNT_W-1:0] r_exp;
  logic             r_err;
  logic [DSZ-1:0]   r_fst_inp;
  logic [DSZ-1:0]   r_fst_exp;

  logic             w_acc;
  logic [CNT_W-1:0] w_nxt;
  logic             w_bad_rt;
  logic             w_bad_rng;
  logic             w_bad_seq;
  logic             w_bad;
  logic             w_unused_dst;

  // Only the slot bits of the address matter here.
  assign w_unused_dst = ^i_dst;

  assign w_acc     = i_req & ~r_ack;
  assign w_nxt     = r_exp + 1'b1;
  assign w_bad_rt  = (`NS_SLOT(i_dst, SEL_W) != SEL_W'(IDX));
  assign w_bad_rng = ((i_dat >> CNT_W) != '0);
  assign w_bad_seq = (i_dat[CNT_W-1:0] != w_nxt);
  assign w_bad     = w_acc & (w_bad_rt | w_bad_rng | w_bad_seq);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ack     <= 1'b0;
      r_exp     <= '1;
      r_err     <= 1'b0;
      r_fst_inp <= '0;
      r_fst_exp <= '0;
    end else begin
      if (w_acc) begin
        r_ack <= 1'b1;
        // Correct data equals exp+1 anyway; on a sequence error this resyncs.
        r_exp <= i_dat[CNT_W-1:0];
      end else if (!i_req && r_ack) begin
        r_ack <= 1'b0;
      end
      if (w_bad) begin
        r_err <= 1'b1;
        if (!r_err) begin
          r_fst_inp <= i_dat;
          r_fst_exp <= DSZ'(w_nxt);
        end
      end
    end
  end

  assign o_ack     = r_ack;
  assign o_err     = r_err;
  assign o_acc     = w_acc;
  assign o_fst_inp = r_fst_inp;
  assign o_fst_exp = r_fst_exp;

endmodule

// File: rtl/io_1ton_chk.sv
// Purpose: NoC test traffic generator (1 source) and checker (NUM_SNK sinks).
// Latency: every req/ack output responds 1 cycle after its triggering input edge.
// Backpressure: 4-phase req/ack; one source message in flight, watchdog flags a stuck ack.
// Ports: i_clk/i_rst; o0_src/o0_dst/o0_dat/o0_req/o0_ack source channel;
//        i_snk_dst/i_snk_dat/i_snk_req/o_snk_ack packed sink channels (sink k at slice k);
//        o_src_err, o_src_tmo, o_snk_err, o_fst_err_inp/exp, o_rx_cnt, o_done status.
`ifndef NS_HGLOBAL_SV
`include "hglobal.sv"
`endif

module io_1ton_chk
  import io_1ton_chk_pkg::*;
#(
  parameter int NUM_SNK  = 4,
  parameter int MIN_ADDR = 0,
  parameter int MAX_ADDR = 7,
  parameter int ASZ      = `NS_ADDRESS_SIZE,
  parameter int DSZ      = `NS_DATA_SIZE,
  parameter int CNT_W    = 4,
  parameter int NUM_MSG  = 0,
  parameter int TMO_CYC  = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  output logic [ASZ-1:0]         o0_src,
  output logic [ASZ-1:0]         o0_dst,
  output logic [DSZ-1:0]         o0_dat,
  output logic                   o0_req,
  input  logic                   o0_ack,
  input  logic [NUM_SNK*ASZ-1:0] i_snk_dst,
  input  logic [NUM_SNK*DSZ-1:0] i_snk_dat,
  input  logic [NUM_SNK-1:0]     i_snk_req,
  output logic [NUM_SNK-1:0]     o_snk_ack,
  output logic                   o_src_err,
  output logic                   o_src_tmo,
  output logic [NUM_SNK-1:0]     o_snk_err,
  output logic [NUM_SNK*DSZ-1:0] o_fst_err_inp,
  output logic [NUM_SNK*DSZ-1:0] o_fst_err_exp,
  output logic [31:0]            o_rx_cnt,
  output logic                   o_done
);

  localparam int SEL_W = $clog2(NUM_SNK);

  src_st_t          r_state;
  src_st_t          w_state_nxt;
  logic [ASZ-1:0]   r_dst;
  logic [DSZ-1:0]   r_dat;
  logic [CNT_W-1:0] r_seq [NUM_SNK];
  logic [31:0]      r_sent;
  logic [31:0]      r_wd;
  logic             r_tmo;
  logic             r_src_err;
  logic [RX_W-1:0]  r_rx;
  logic             r_done;

  logic               w_req;
  logic               w_load;
  logic               w_fin;
  logic               w_wd_run;
  logic               w_all_sent;
  logic [SEL_W-1:0]   w_slot;
  logic [NUM_SNK-1:0] w_acc;
  logic [RX_W-1:0]    w_pop;

  assign w_all_sent = (NUM_MSG != 0) && (r_sent == 32'(NUM_MSG));
  assign w_slot     = `NS_SLOT(r_dst, SEL_W);

  // ---------------- source FSM: state register ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= SRC_IDLE;
    else       r_state <= w_state_nxt;
  end

  // ---------------- source FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // A new request waits for the previous ack to be seen low.
      SRC_IDLE: if (!o0_ack && !w_all_sent) w_state_nxt = SRC_WAIT;
      SRC_WAIT: if (o0_ack)                 w_state_nxt = SRC_IDLE;
      default:                              w_state_nxt = SRC_IDLE;
    endcase
  end

  // ---------------- source FSM: outputs ----------------
  always_comb begin
    w_req    = (r_state == SRC_WAIT);
    w_load   = (r_state == SRC_IDLE) && (w_state_nxt == SRC_WAIT);
    w_fin    = (r_state == SRC_WAIT) && (w_state_nxt == SRC_IDLE);
    w_wd_run = (r_state == SRC_WAIT) && !o0_ack;
  end

  // ---------------- source datapath ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dst  <= ASZ'(MIN_ADDR);
      r_dat  <= '0;
      r_sent <= '0;
      for (int k = 0; k < NUM_SNK; k++) r_seq[k] <= '0;
    end else begin
      if (w_load) begin
        r_dat         <= DSZ'(r_seq[w_slot]);
        r_seq[w_slot] <= r_seq[w_slot] + 1'b1;
      end
      if (w_fin) begin
        r_dst  <= (r_dst >= ASZ'(MAX_ADDR)) ? ASZ'(MIN_ADDR) : r_dst + 1'b1;
        r_sent <= r_sent + 32'd1;
      end
    end
  end

  // ---------------- watchdog and source data guard ----------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wd      <= '0;
      r_tmo     <= 1'b0;
      r_src_err <= 1'b0;
    end else begin
      if (!w_req) begin
        r_wd <= '0;
      end else if (TMO_CYC != 0 && w_wd_run && !r_tmo) begin
        // Flag on the TMO_CYC-th stalled cycle, then freeze the count.
        if (r_wd == 32'(TMO_CYC - 1)) r_tmo <= 1'b1;
        else                          r_wd  <= r_wd + 32'd1;
      end
      if ((r_dat >> CNT_W) != '0) r_src_err <= 1'b1;
    end
  end

  // ---------------- sinks ----------------
  for (genvar k = 0; k < NUM_SNK; k++) begin : g_snk
    io_snk_chk #(
      .IDX  (k),
      .SEL_W(SEL_W),
      .ASZ  (ASZ),
      .DSZ  (DSZ),
      .CNT_W(CNT_W)
    ) u_snk (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_dst    (i_snk_dst[k*ASZ +: ASZ]),
      .i_dat    (i_snk_dat[k*DSZ +: DSZ]),
      .i_req    (i_snk_req[k]),
      .o_ack    (o_snk_ack[k]),
      .o_err    (o_snk_err[k]),
      .o_acc    (w_acc[k]),
      .o_fst_inp(o_fst_err_inp[k*DSZ +: DSZ]),
      .o_fst_exp(o_fst_err_exp[k*DSZ +: DSZ])
    );
  end

  // ---------------- receive counter and done ----------------
  // Sinks are independent, so several may accept in the same cycle.
  always_comb begin
    w_pop = '0;
    for (int k = 0; k < NUM_SNK; k++) w_pop = w_pop + RX_W'(w_acc[k]);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rx   <= '0;
      r_done <= 1'b0;
    end else begin
      r_rx <= sat_add(r_rx, w_pop);
      // Done once the final ack has been seen low with nothing left to send.
      if (r_state == SRC_IDLE && w_all_sent && !o0_ack) r_done <= 1'b1;
    end
  end

  assign o0_src    = '0;
  assign o0_dst    = r_dst;
  assign o0_dat    = r_dat;
  assign o0_req    = w_req;
  assign o_src_err = r_src_err;
  assign o_src_tmo = r_tmo;
  assign o_rx_cnt  = r_rx;
  assign o_done    = r_done;

endmodule

// File: tb/tb_io_1ton_chk.sv
module tb_io_1ton_chk;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Instance a: 4 sinks, addresses 0..7, 64 messages, 10-cycle watchdog.
  logic [7:0]  a_src, a_dst, a_dat;
  logic        a_req, a_ack;
  logic [31:0] a_sdst, a_sdat, a_finp, a_fexp, a_rx;
  logic [3:0]  a_sreq, a_sack, a_serr;
  logic        a_src_err, a_tmo, a_done;

  // Instance b: single destination address 1, 40 messages, no watchdog.
  logic [7:0]  b_src, b_dst, b_dat;
  logic        b_req, b_ack;
  logic [31:0] b_sdst, b_sdat, b_finp, b_fexp, b_rx;
  logic [3:0]  b_sreq, b_sack, b_serr;
  logic        b_src_err, b_tmo, b_done;

  io_1ton_chk #(.NUM_SNK(4), .MIN_ADDR(0), .MAX_ADDR(7), .ASZ(8), .DSZ(8),
                .CNT_W(4), .NUM_MSG(64), .TMO_CYC(10)) u_dut_a (
    .i_clk(clk), .i_rst(rst),
    .o0_src(a_src), .o0_dst(a_dst), .o0_dat(a_dat), .o0_req(a_req), .o0_ack(a_ack),
    .i_snk_dst(a_sdst), .i_snk_dat(a_sdat), .i_snk_req(a_sreq), .o_snk_ack(a_sack),
    .o_src_err(a_src_err), .o_src_tmo(a_tmo), .o_snk_err(a_serr),
    .o_fst_err_inp(a_finp), .o_fst_err_exp(a_fexp), .o_rx_cnt(a_rx), .o_done(a_done)
  );

  io_1ton_chk #(.NUM_SNK(4), .MIN_ADDR(1), .MAX_ADDR(1), .ASZ(8), .DSZ(8),
                .CNT_W(4), .NUM_MSG(40), .TMO_CYC(0)) u_dut_b (
    .i_clk(clk), .i_rst(rst),
    .o0_src(b_src), .o0_dst(b_dst), .o0_dat(b_dat), .o0_req(b_req), .o0_ack(b_ack),
    .i_snk_dst(b_sdst), .i_snk_dat(b_sdat), .i_snk_req(b_sreq), .o_snk_ack(b_sack),
    .o_src_err(b_src_err), .o_src_tmo(b_tmo), .o_snk_err(b_serr),
    .o_fst_err_inp(b_finp), .o_fst_err_exp(b_fexp), .o_rx_cnt(b_rx), .o_done(b_done)
  );

  // Reference source state for instance a.
  int mseq [4];
  int mdst;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) mseq[k] = 0;
    mdst = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a_sreq = '0; a_ack = 1'b0;
    b_sreq = '0; b_ack = 1'b0;
    step();
    step();
    rst = 1'b0;
    model_clear();
  endtask

  // One message through the bench network model of instance a.
  // mode 0: deliver to slot(dst); 1: swallow; 2: misroute to sink 0.
  task automatic xfer(input int mode);
    logic [7:0] dst, dat;
    int s;
    for (int n = 0; n < 20 && a_req !== 1'b1; n++) step();
    chk("src_req_hi", {31'd0, a_req}, 32'd1);
    dst = a_dst;
    dat = a_dat;
    chk("src_dst", {24'd0, dst}, mdst);
    chk("src_dat", {24'd0, dat}, mseq[mdst % 4]);
    mseq[mdst % 4] = (mseq[mdst % 4] + 1) % 16;
    mdst = (mdst >= 7) ? 0 : mdst + 1;
    if (mode != 1) begin
      s = (mode == 2) ? 0 : int'(dst[1:0]);
      a_sdst[s*8 +: 8] = dst;
      a_sdat[s*8 +: 8] = dat;
      a_sreq[s] = 1'b1;
      for (int n = 0; n < 20 && a_sack[s] !== 1'b1; n++) step();
      chk("snk_ack_hi", {31'd0, a_sack[s]}, 32'd1);
      a_sreq[s] = 1'b0;
      for (int n = 0; n < 20 && a_sack[s] !== 1'b0; n++) step();
      chk("snk_ack_lo", {31'd0, a_sack[s]}, 32'd0);
    end
    a_ack = 1'b1;
    for (int n = 0; n < 20 && a_req !== 1'b0; n++) step();
    chk("src_req_lo", {31'd0, a_req}, 32'd0);
    a_ack = 1'b0;
  endtask

  initial begin
    a_ack = 1'b0; a_sdst = '0; a_sdat = '0; a_sreq = '0;
    b_ack = 1'b0; b_sdst = '0; b_sdat = '0; b_sreq = '0;
    model_clear();

    // ---- reset state ----
    step(); step(); step();
    chk("rst_req",   {31'd0, a_req}, 32'd0);
    chk("rst_dst_a", {24'd0, a_dst}, 32'd0);
    chk("rst_dst_b", {24'd0, b_dst}, 32'd1);
    chk("rst_dat",   {24'd0, a_dat}, 32'd0);
    chk("rst_rx",    a_rx, 32'd0);
    chk("rst_sack",  {28'd0, a_sack}, 32'd0);
    chk("rst_serr",  {28'd0, a_serr}, 32'd0);
    chk("rst_flags", {29'd0, a_done, a_tmo, a_src_err}, 32'd0);
    chk("rst_finp",  a_finp, 32'd0);
    rst = 1'b0;

    // ---- clean loopback: 64 messages, each sink sees 0..15 ----
    for (int i = 0; i < 64; i++) begin
      xfer(0);
      if (i == 15) chk("lb_rx16", a_rx, 32'd16);
    end
    for (int n = 0; n < 10 && a_done !== 1'b1; n++) step();
    chk("lb_done",  {31'd0, a_done}, 32'd1);
    chk("lb_rx",    a_rx, 32'd64);
    chk("lb_serr",  {28'd0, a_serr}, 32'd0);
    chk("lb_flags", {30'd0, a_tmo, a_src_err}, 32'd0);
    step(); step(); step();
    chk("lb_no_req", {31'd0, a_req}, 32'd0);

    // ---- reset with source request and two sinks acking ----
    do_reset();
    for (int n = 0; n < 10 && a_req !== 1'b1; n++) step();
    chk("mid_req", {31'd0, a_req}, 32'd1);
    a_sdst[8 +: 8]  = 8'd1; a_sdat[8 +: 8]  = 8'd0;
    a_sdst[24 +: 8] = 8'd3; a_sdat[24 +: 8] = 8'd0;
    a_sreq = 4'b1010;
    step();
    chk("mid_sack", {28'd0, a_sack}, 32'hA);
    chk("mid_rx2",  a_rx, 32'd2);
    chk("mid_serr", {28'd0, a_serr}, 32'd0);
    rst = 1'b1;
    a_sreq = '0;
    step();
    chk("rstm_req",  {31'd0, a_req}, 32'd0);
    chk("rstm_sack", {28'd0, a_sack}, 32'd0);
    chk("rstm_rx",   a_rx, 32'd0);
    chk("rstm_serr", {28'd0, a_serr}, 32'd0);
    chk("rstm_dst",  {24'd0, a_dst}, 32'd0);
    rst = 1'b0;
    model_clear();

    // ---- misroute: msg with dst=5 (dat 1) delivered to sink 0 ----
    for (int i = 0; i < 5; i++) xfer(0);
    chk("mis_pre_serr", {28'd0, a_serr}, 32'd0);
    xfer(2);
    chk("mis_serr", {28'd0, a_serr}, 32'd1);
    chk("mis_finp", {24'd0, a_finp[7:0]}, 32'd1);
    chk("mis_fexp", {24'd0, a_fexp[7:0]}, 32'd2);

    // ---- dropped message: sink 2's third message (dat 2) swallowed ----
    do_reset();
    for (int i = 0; i < 24; i++) xfer((i == 10) ? 1 : 0);
    chk("drop_serr", {28'd0, a_serr}, 32'd4);
    chk("drop_finp", {24'd0, a_finp[23:16]}, 32'd3);
    chk("drop_fexp", {24'd0, a_fexp[23:16]}, 32'd2);
    chk("drop_rx",   a_rx, 32'd23);

    // ---- stalled ack: watchdog fires exactly 10 cycles after req ----
    do_reset();
    for (int n = 0; n < 10 && a_req !== 1'b1; n++) step();
    chk("tmo_req", {31'd0, a_req}, 32'd1);
    for (int n = 0; n < 9; n++) step();
    chk("tmo_early", {31'd0, a_tmo}, 32'd0);
    step();
    chk("tmo_set", {31'd0, a_tmo}, 32'd1);
    step(); step(); step();
    chk("tmo_req_hold", {31'd0, a_req}, 32'd1);
    chk("tmo_sticky",   {31'd0, a_tmo}, 32'd1);

    // ---- sequence wrap on instance b: 40 messages to sink 1 ----
    do_reset();
    for (int i = 0; i < 40; i++) begin
      for (int n = 0; n < 20 && b_req !== 1'b1; n++) step();
      chk("w_req_hi", {31'd0, b_req}, 32'd1);
      chk("w_dst", {24'd0, b_dst}, 32'd1);
      chk("w_dat", {24'd0, b_dat}, i % 16);
      b_sdst[8 +: 8] = b_dst;
      b_sdat[8 +: 8] = b_dat;
      b_sreq[1] = 1'b1;
      for (int n = 0; n < 20 && b_sack[1] !== 1'b1; n++) step();
      chk("w_ack_hi", {31'd0, b_sack[1]}, 32'd1);
      b_sreq[1] = 1'b0;
      for (int n = 0; n < 20 && b_sack[1] !== 1'b0; n++) step();
      b_ack = 1'b1;
      for (int n = 0; n < 20 && b_req !== 1'b0; n++) step();
      chk("w_req_lo", {31'd0, b_req}, 32'd0);
      b_ack = 1'b0;
    end
    for (int n = 0; n < 10 && b_done !== 1'b1; n++) step();
    chk("w_done", {31'd0, b_done}, 32'd1);
    chk("w_rx",   b_rx, 32'd40);
    chk("w_serr", {28'd0, b_serr}, 32'd0);
    chk("w_flags", {30'd0, b_tmo, b_src_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
